// File: rtl/raytracing_line_scheduler_pkg.sv
// Shared ray-tracer types: fixed-point widths, scene sphere record, pixel color
// and the line scheduler state encoding.
package Types;

  localparam int FP_B    = 4;
  localparam int DOT_Y_B = 28;

  typedef logic [7:0] Color;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic [7:0]         r;
    Color               color;
  } Sphere;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_1,
    SETUP_2,
    LAUNCH,
    RENDER,
    COMMIT
  } sched_state_e;

  localparam Sphere SPHERE_RESET = '{x: -16'sd300, y: -16'sd200, z: 16'sd150,
                                     r: 8'd5, color: 8'd0};

  // A one-sphere bank still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raytracing_line_scheduler_scene.sv
// Double-buffered scene store: writes land in the shadow bank at any time,
// and the whole shadow bank is copied to the active bank at frame start.
module raytracing_scene_bank
  import Types::*;
#(
  parameter int N_SPHERES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [idx_w(N_SPHERES)-1:0]  wr_idx,
  input  Sphere                        wr_word,
  input  logic                         commit,
  input  logic [idx_w(N_SPHERES)-1:0]  rd_idx,
  output Sphere                        rd_sphere
);

  localparam int IDX_W = idx_w(N_SPHERES);

  Sphere shadow [N_SPHERES];
  Sphere active [N_SPHERES];

  // A write coinciding with the frame copy is forwarded straight into the
  // active bank so the new frame already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SPHERES; i++) begin
        shadow[i] <= SPHERE_RESET;
        active[i] <= SPHERE_RESET;
      end
    end else begin
      for (int i = 0; i < N_SPHERES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) shadow[i] <= wr_word;
        if (commit) active[i] <= (wr_en && (wr_idx == IDX_W'(i))) ? wr_word : shadow[i];
      end
    end
  end

  assign rd_sphere = active[rd_idx];

endmodule

// File: rtl/raytracing_line_scheduler.sv
// Line scheduler: per requested VGA line, runs one worker pass per sphere,
// then latches the finished line for display.
module raytracing_line_scheduler
  import Types::*;
#(
  parameter int JOBS      = 640,
  parameter int N_WORKERS = 10,
  parameter int N_SPHERES = 4,
  parameter int LINES     = 480
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst_,
  input  logic                          scene_dv,
  input  logic [idx_w(N_SPHERES)-1:0]   scene_idx,
  input  Sphere                         scene_word,
  output logic                          recv_interrupt,
  input  logic                          next_line,
  input  logic [11:0]                   next_y,
  output logic                          worker_activate,
  output logic                          worker_first_pass,
  input  logic [N_WORKERS-1:0]          worker_busy,
  output Sphere                         sphere,
  output logic [15:0]                   pixel_y_sqrd,
  output logic signed [DOT_Y_B-1:0]     doty_r,
  output logic [26:0]                   sphere_y_sqrd,
  input  Color                          line_color_buffer [JOBS],
  output Color                          line_color [JOBS],
  output logic                          overrun,
  output sched_state_e                  state_dbg
);

  localparam int               IDX_W  = idx_w(N_SPHERES);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(N_SPHERES - 1);
  localparam logic [11:0]      Y_MID  = 12'(LINES / 2);

  sched_state_e state, state_d;
  logic [IDX_W-1:0] p, p_d;
  logic next_line_q, line_req, frame_copy, render_settled;
  logic [11:0] y_lat;
  logic signed [11:0] pixel_y;
  Sphere bank_sphere;

  logic signed [DOT_Y_B-1:0] py_ext, sy_ext;
  logic signed [31:0]        sy_wide, sy_sq;
  logic [15:0]               pys_c;
  logic [26:0]               ysq_c;

  assign line_req       = next_line & ~next_line_q;
  assign frame_copy     = (state == IDLE) && line_req && (next_y == 12'd0);
  assign recv_interrupt = (state == IDLE);
  assign state_dbg      = state;

  raytracing_scene_bank #(.N_SPHERES(N_SPHERES)) u_bank (
    .clk       (CLK100MHZ),
    .rst_n     (ck_rst_),
    .wr_en     (scene_dv),
    .wr_idx    (scene_idx),
    .wr_word   (scene_word),
    .commit    (frame_copy),
    .rd_idx    (p),
    .rd_sphere (bank_sphere)
  );

  assign py_ext  = {{(DOT_Y_B-12){pixel_y[11]}}, pixel_y};
  assign sy_ext  = {{(DOT_Y_B-16){sphere.y[15]}}, sphere.y};
  assign sy_wide = {{16{bank_sphere.y[15]}}, bank_sphere.y};
  assign sy_sq   = sy_wide * sy_wide;
  assign ysq_c   = 27'(sy_sq >>> FP_B);
  assign pys_c   = 16'(py_ext * py_ext);

  always_comb begin
    state_d = state;
    p_d     = p;
    case (state)
      IDLE:    if (line_req) begin
                 state_d = SETUP_1;
                 p_d     = '0;
               end
      SETUP_1: state_d = SETUP_2;
      SETUP_2: state_d = LAUNCH;
      LAUNCH:  state_d = RENDER;
      // Busy is ignored in the first RENDER cycle while workers pick up the start.
      RENDER:  if (render_settled && (worker_busy == '0)) begin
                 if (p < LAST_P) begin
                   p_d     = p + 1'b1;
                   state_d = SETUP_1;
                 end else begin
                   state_d = COMMIT;
                 end
               end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      state             <= IDLE;
      p                 <= '0;
      next_line_q       <= 1'b1;
      render_settled    <= 1'b0;
      y_lat             <= '0;
      pixel_y           <= '0;
      sphere            <= '0;
      worker_activate   <= 1'b0;
      worker_first_pass <= 1'b0;
      pixel_y_sqrd      <= '0;
      doty_r            <= '0;
      sphere_y_sqrd     <= '0;
      overrun           <= 1'b0;
    end else begin
      state             <= state_d;
      p                 <= p_d;
      next_line_q       <= next_line;
      render_settled    <= (state == RENDER);
      worker_activate   <= (state_d == LAUNCH);
      worker_first_pass <= (state_d == LAUNCH) && (p_d == '0);
      if ((state == IDLE) && line_req) y_lat <= next_y;
      if (state == SETUP_1) begin
        pixel_y       <= $signed(y_lat - Y_MID);
        sphere        <= bank_sphere;
        sphere_y_sqrd <= ysq_c;
      end
      if (state == SETUP_2) begin
        pixel_y_sqrd <= pys_c;
        doty_r       <= py_ext * sy_ext;
      end
      if (line_req && (state != IDLE)) overrun <= 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      for (int j = 0; j < JOBS; j++) line_color[j] <= '0;
    end else if (state == COMMIT) begin
      for (int j = 0; j < JOBS; j++) line_color[j] <= line_color_buffer[j];
    end
  end

endmodule

// File: tb/tb_raytracing_line_scheduler.sv
// Randomized scoreboard bench for the line scheduler with a behavioural
// scene/line model and a simple worker responder.
module tb_raytracing_line_scheduler;
  import Types::*;

  localparam int JOBS  = 8;
  localparam int NW    = 2;
  localparam int NS    = 4;
  localparam int LINES = 480;
  localparam int LW    = JOBS * 8;
  localparam int PW    = 64 + 1 + 16 + DOT_Y_B + 27;
  localparam int SW    = 64 + 16 + DOT_Y_B + 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic ck_rst_ = 1'b1;
  initial forever #5 clk = ~clk;

  logic                      scene_dv = 1'b0;
  logic [1:0]                scene_idx = '0;
  Sphere                     scene_word = '0;
  logic                      recv_interrupt;
  logic                      next_line = 1'b0;
  logic [11:0]               next_y = '0;
  logic                      worker_activate, worker_first_pass;
  logic [NW-1:0]             worker_busy = '0;
  Sphere                     sphere;
  logic [15:0]               pixel_y_sqrd;
  logic signed [DOT_Y_B-1:0] doty_r;
  logic [26:0]               sphere_y_sqrd;
  Color                      buf_c [JOBS];
  Color                      line_color [JOBS];
  logic                      overrun;
  sched_state_e              state_dbg;

  raytracing_line_scheduler #(.JOBS(JOBS), .N_WORKERS(NW), .N_SPHERES(NS), .LINES(LINES)) dut (
    .CLK100MHZ         (clk),
    .ck_rst_           (ck_rst_),
    .scene_dv          (scene_dv),
    .scene_idx         (scene_idx),
    .scene_word        (scene_word),
    .recv_interrupt    (recv_interrupt),
    .next_line         (next_line),
    .next_y            (next_y),
    .worker_activate   (worker_activate),
    .worker_first_pass (worker_first_pass),
    .worker_busy       (worker_busy),
    .sphere            (sphere),
    .pixel_y_sqrd      (pixel_y_sqrd),
    .doty_r            (doty_r),
    .sphere_y_sqrd     (sphere_y_sqrd),
    .line_color_buffer (buf_c),
    .line_color        (line_color),
    .overrun           (overrun),
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard state and model ----------------
  logic [PW-1:0] exp_q[$];
  logic [LW-1:0] line_q[$];
  int checks = 0;
  int errors = 0;

  Sphere       m_shadow [NS];
  Sphere       m_active [NS];
  bit          m_overrun = 1'b0;
  logic [LW-1:0] buf_vec = '0;
  logic [LW-1:0] last_line = '0;
  bit          hold_long = 1'b0;
  int          busy_left = 0;
  int          start_dly = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pass_exp(input Sphere s, input bit first, input logic [11:0] y);
    longint py, sy;
    logic [15:0] pys;
    logic [DOT_Y_B-1:0] dot;
    logic [26:0] ysq;
    py  = longint'(y) - LINES / 2;
    sy  = longint'($signed(s.y));
    pys = 16'(py * py);
    dot = DOT_Y_B'(py * sy);
    ysq = 27'((sy * sy) / (64'sd1 << FP_B));
    return {s, first, pys, dot, ysq};
  endfunction

  function automatic Sphere rand_sphere();
    Sphere s;
    s.x = 16'($urandom);
    s.y = 16'($urandom);
    s.z = 16'($urandom);
    s.r = 8'($urandom);
    s.color = 8'($urandom);
    return s;
  endfunction

  function automatic logic [LW-1:0] packed_line();
    logic [LW-1:0] v;
    for (int j = 0; j < JOBS; j++) v[j*8 +: 8] = line_color[j];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_shadow[i] = SPHERE_RESET;
      m_active[i] = SPHERE_RESET;
    end
    m_overrun = 1'b0;
    last_line = '0;
    exp_q.delete();
    line_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_buffer();
    for (int j = 0; j < JOBS; j++) begin
      buf_vec[j*8 +: 8] = 8'($urandom);
      buf_c[j] = buf_vec[j*8 +: 8];
    end
  endtask

  task automatic scene_write(input logic [1:0] idx, input Sphere w);
    @(negedge clk);
    scene_dv = 1'b1;
    scene_idx = idx;
    scene_word = w;
    m_shadow[idx] = w;
    @(negedge clk);
    scene_dv = 1'b0;
  endtask

  // Requests a line while the scheduler is idle; optionally a scene write in the same cycle.
  task automatic issue_line(input logic [11:0] y, input bit with_wr, input logic [1:0] idx, input Sphere w);
    @(negedge clk);
    next_y = y;
    next_line = 1'b1;
    if (with_wr) begin
      scene_dv = 1'b1;
      scene_idx = idx;
      scene_word = w;
      m_shadow[idx] = w;
    end
    if (y == 12'd0) for (int i = 0; i < NS; i++) m_active[i] = m_shadow[i];
    for (int i = 0; i < NS; i++) exp_q.push_back(pass_exp(m_active[i], i == 0, y));
    line_q.push_back(buf_vec);
    @(negedge clk);
    next_line = 1'b0;
    scene_dv = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (recv_interrupt) done = 1'b1;
    end
    if (!done) check("line_done_timeout", 0, 1);
    else last_line = buf_vec;
  endtask

  task automatic wait_busy();
    bit seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (worker_busy != '0) seen = 1'b1;
    end
    if (!seen) check("busy_timeout", 0, 1);
  endtask

  task automatic render_line(input logic [11:0] y);
    set_buffer();
    issue_line(y, 1'b0, 2'd0, '0);
    wait_done();
  endtask

  // ---------------- worker responder ----------------
  initial begin
    logic [SW-1:0] snap;
    forever begin
      @(negedge clk);
      if (!ck_rst_) begin
        busy_left = 0;
        start_dly = 0;
        worker_busy = '0;
        continue;
      end
      if (worker_activate) begin
        check("idle_at_activate", (busy_left != 0) || (start_dly != 0), 0);
        busy_left = hold_long ? 40 : $urandom_range(0, 6);
        start_dly = 2;
        snap = {sphere, pixel_y_sqrd, doty_r, sphere_y_sqrd};
      end else if (start_dly > 0) begin
        start_dly--;
        if (start_dly == 0 && busy_left > 0) worker_busy = NW'($urandom_range(1, (1 << NW) - 1));
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          worker_busy = '0;
          check("hold_stable", {sphere, pixel_y_sqrd, doty_r, sphere_y_sqrd}, snap);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit ri_prev = 1'b1;
    logic [PW-1:0] e;
    logic [LW-1:0] le;
    forever begin
      @(negedge clk);
      if (!ck_rst_) begin
        ri_prev = 1'b1;
        continue;
      end
      if (worker_activate) begin
        if (exp_q.size() == 0) check("unexpected_activate", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pass", {sphere, worker_first_pass, pixel_y_sqrd, doty_r, sphere_y_sqrd}, e);
        end
      end
      if (recv_interrupt && !ri_prev) begin
        if (line_q.size() == 0) check("unexpected_line", 1, 0);
        else begin
          le = line_q.pop_front();
          check("line_color", packed_line(), le);
          check("overrun_at_line", overrun, m_overrun);
        end
      end
      ri_prev = recv_interrupt;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Sphere w;
    logic [11:0] y;
    logic [1:0] idx;
    bit coinc;

    for (int j = 0; j < JOBS; j++) buf_c[j] = '0;
    #1 ck_rst_ = 1'b0;
    model_reset();
    #1;
    check("rst_recv_interrupt", recv_interrupt, 1);
    check("rst_activate", worker_activate, 0);
    check("rst_first_pass", worker_first_pass, 0);
    check("rst_overrun", overrun, 0);
    check("rst_line_color", packed_line(), 0);
    check("rst_pixel_y_sqrd", pixel_y_sqrd, 0);
    check("rst_doty_r", doty_r, 0);
    check("rst_sphere_y_sqrd", sphere_y_sqrd, 0);
    repeat (3) @(negedge clk);
    ck_rst_ = 1'b1;
    repeat (3) @(negedge clk);

    // Scene with every sphere at y = -200 in fixed point; then lines 0 and 240.
    for (int i = 0; i < NS; i++) begin
      w = rand_sphere();
      w.y = -16'sd3200;
      scene_write(2'(i), w);
    end
    render_line(12'd0);
    render_line(12'd240);

    // Shadow write mid-frame reaches the active bank only at the next line 0.
    scene_write(2'd2, rand_sphere());
    render_line(12'd100);
    render_line(12'd101);
    render_line(12'd0);

    // Scene write in the same cycle as the frame copy.
    set_buffer();
    issue_line(12'd0, 1'b1, 2'd1, rand_sphere());
    wait_done();
    render_line(12'd7);

    // Randomized lines with scene writes before, alongside and during renders.
    for (int it = 0; it < 20; it++) begin
      set_buffer();
      y = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, LINES - 1));
      coinc = ($urandom_range(0, 3) == 0);
      idx = 2'($urandom_range(0, NS - 1));
      if ($urandom_range(0, 1) == 1) scene_write(2'($urandom_range(0, NS - 1)), rand_sphere());
      issue_line(y, coinc, idx, rand_sphere());
      if ($urandom_range(0, 2) == 0) scene_write(2'($urandom_range(0, NS - 1)), rand_sphere());
      wait_done();
    end

    // Line request while workers are still busy: must be dropped and flagged.
    scene_write(2'd3, rand_sphere());
    hold_long = 1'b1;
    set_buffer();
    issue_line(12'd50, 1'b0, 2'd0, '0);
    wait_busy();
    @(negedge clk);
    next_y = 12'd0;
    next_line = 1'b1;
    @(negedge clk);
    next_line = 1'b0;
    m_overrun = 1'b1;
    check("overrun_set", overrun, 1);
    check("overrun_line_hold", packed_line(), last_line);
    hold_long = 1'b0;
    wait_done();
    render_line(12'd0);
    render_line(12'd479);

    // Asynchronous reset in the middle of a render.
    hold_long = 1'b1;
    set_buffer();
    issue_line(12'd300, 1'b0, 2'd0, '0);
    wait_busy();
    #2 ck_rst_ = 1'b0;
    #1;
    check("mid_rst_activate", worker_activate, 0);
    check("mid_rst_first_pass", worker_first_pass, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_line_color", packed_line(), 0);
    check("mid_rst_pixel_y_sqrd", pixel_y_sqrd, 0);
    check("mid_rst_doty_r", doty_r, 0);
    check("mid_rst_sphere_y_sqrd", sphere_y_sqrd, 0);
    check("mid_rst_recv_interrupt", recv_interrupt, 1);
    model_reset();
    hold_long = 1'b0;
    repeat (2) @(negedge clk);
    ck_rst_ = 1'b1;
    repeat (3) @(negedge clk);
    render_line(12'd5);
    render_line(12'd0);

    repeat (5) @(negedge clk);
    check("pass_queue_empty", exp_q.size(), 0);
    check("line_queue_empty", line_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raytracing_line_scheduler.md
RAYTRACING_LINE_SCHEDULER -- requirements
Module: raytracing_line_scheduler

Interface
REQ-001 SHALL have parameter JOBS, default 640, meaning pixels per line.
REQ-002 SHALL have parameter N_WORKERS, default 10, meaning worker count; JOBS SHALL be divisible by N_WORKERS.
REQ-003 SHALL have parameter N_SPHERES, default 4, meaning scene bank depth, from 1 to 16.
REQ-004 SHALL have parameter LINES, default 480, meaning visible lines per frame.
REQ-005 SHALL have port CLK100MHZ  in  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port ck_rst_  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port scene_dv  in  1  scene word valid, one-cycle pulse.
REQ-008 SHALL have port scene_idx  in  $clog2(N_SPHERES)  target slot in the shadow bank.
REQ-009 SHALL have port scene_word  in  64  packed Types::Sphere.
REQ-010 SHALL have port recv_interrupt  out  1  high while a scene write is safe (IDLE state).
REQ-011 SHALL have port next_line  in  1  level from VGA; a rising edge requests a line.
REQ-012 SHALL have port next_y  in  12  line index (0..LINES-1) to render.
REQ-013 SHALL have port worker_activate  out  1  start pulse for the current pass.
REQ-014 SHALL have port worker_first_pass  out  1  high with the pass-0 activate; workers clear their depth and color.
REQ-015 SHALL have port worker_busy  in  N_WORKERS  per-worker busy.
REQ-016 SHALL have port sphere  out  64  active sphere for the current pass.
REQ-017 SHALL have port pixel_y_sqrd  out  16  pixel_y squared, unsigned.
REQ-018 SHALL have port doty_r  out  DOT_Y_B  pixel_y times sphere.y, signed.
REQ-019 SHALL have port sphere_y_sqrd  out  27  (sphere.y squared) >>> FP_B.
REQ-020 SHALL have port line_color_buffer  in  JOBS x Color  worker results.
REQ-021 SHALL have port line_color  out  JOBS x Color  registered line sent to VGA.
REQ-022 SHALL have port overrun  out  1  sticky flag; a line was missed.

Function
REQ-023 SHALL implement states IDLE, SETUP_1, SETUP_2, LAUNCH, RENDER, COMMIT.
REQ-024 SHALL, in IDLE, move to SETUP_1 on a next_line rising edge and latch next_y; pass index p = 0.
REQ-025 SHALL, in SETUP_1, register pixel_y = next_y - LINES/2 (signed 12 bit), drive sphere = active[p], and compute sphere_y_sqrd.
REQ-026 SHALL, in SETUP_2, compute pixel_y_sqrd and doty_r (inputs sign-extended to DOT_Y_B), then go to LAUNCH.
REQ-027 SHALL, in LAUNCH, pulse worker_activate for exactly one cycle (worker_first_pass = (p==0)), then go to RENDER.
REQ-028 SHALL, in RENDER, wait one cycle, then wait until worker_busy == 0.
REQ-029 SHALL, after RENDER, go to SETUP_1 with p+1 if p < N_SPHERES-1; otherwise go to COMMIT.
REQ-030 SHALL, in COMMIT, load line_color from line_color_buffer in one cycle and return to IDLE; line_color SHALL change only here.
REQ-031 SHALL write scene_word into shadow[scene_idx] on a scene_dv pulse in any state.
REQ-032 SHALL copy the shadow bank to the active bank only in IDLE on a next_line edge with next_y == 0, so a frame never mixes scenes.
REQ-033 SHALL, when a scene_dv pulse and the frame copy occur in the same cycle, put the new word in both banks.
REQ-034 SHALL ignore a next_line rising edge outside IDLE (no line_color update for it), set overrun, and leave the FSM undisturbed.
REQ-035 SHALL clear overrun only by reset.
REQ-036 SHALL hold worker outputs stable from LAUNCH until the end of RENDER.

Reset
REQ-037 SHALL, on ck_rst_ low, immediately set: state IDLE, p=0, worker_activate=0, worker_first_pass=0, overrun=0, line_color=0, pixel_y_sqrd=0, doty_r=0, sphere_y_sqrd=0, next_line edge detector=1.
REQ-038 SHALL reset both banks to sphere {x=-300, y=-200, z=150, r=5, color=0}; recv_interrupt SHALL read 1 after reset.
REQ-039 SHALL, on a reset mid-RENDER, discard the line and drop worker_activate asynchronously.

Structure
REQ-040 SHALL have Types::Sphere, Types::Color, FP_B and DOT_Y_B come from the shared Types package; the scheduler state enum SHALL be added there.
REQ-041 SHALL have one sub-module, raytracing_scene_bank (shadow/active register file with frame-commit copy).

Verification
REQ-042 SHALL cover: next_y=240, sphere.y=-200<<FP_B -> pixel_y_sqrd=0, doty_r=0, N_SPHERES activate pulses, first_pass only on the first.
REQ-043 SHALL cover: next_y=0, pixel_y=-240 -> pixel_y_sqrd=57600.
REQ-044 SHALL cover: scene_dv idx 2 at y=100 -> active[2] unchanged until the next next_y=0 edge, then updated.
REQ-045 SHALL cover: next_line edge while worker_busy is held high -> overrun=1, line_color unchanged.
REQ-046 SHALL cover: scene_dv coincident with the frame copy -> new word appears in the active bank.
REQ-047 SHALL cover: ck_rst_ low during RENDER -> all outputs at reset values in the same cycle, and a clean render of the next line.
